// File: rtl/cdb_complete_arbiter.sv
// Complete stage: per-lane holding registers for finished execute results,
// a round-robin pick of up to C held lanes per cycle, and C registered CDB
// broadcast slots feeding ROB, RS wakeup and PRF write.
module cdb_complete_arbiter #(
  parameter int N         = 5,
  parameter int C         = 3,
  parameter int XLEN      = 32,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           ex_done,
  input  logic [N*XLEN-1:0]      ex_result,
  input  logic [N*PRF_IDX_W-1:0] ex_dest_prf,
  input  logic [N*ROB_IDX_W-1:0] ex_rob_idx,
  input  logic [N-1:0]           ex_take_branch,
  input  logic                   squash,
  output logic [N-1:0]           fu_stall,
  output logic [C-1:0]           cdb_valid,
  output logic [C*XLEN-1:0]      cdb_result,
  output logic [C*PRF_IDX_W-1:0] cdb_dest_prf,
  output logic [C*ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [C-1:0]           cdb_take_branch
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(C + 1);
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(N - 1);
  localparam logic [PTR_W:0]   N_EXT     = (PTR_W + 1)'(N);
  localparam logic [CNT_W-1:0] C_CNT     = CNT_W'(C);

  // Handshake: lane i offers a result with ex_done[i]. The result is taken on
  // the rising edge unless fu_stall[i] is high in that cycle, in which case
  // the lane must keep ex_done and its payload stable until fu_stall drops.
  // fu_stall is a function of held state only, never of ex_done.

  logic [N-1:0]         held_valid;
  logic [XLEN-1:0]      held_result [N];
  logic [PRF_IDX_W-1:0] held_dest   [N];
  logic [ROB_IDX_W-1:0] held_rob    [N];
  logic [N-1:0]         held_branch;
  logic [PTR_W-1:0]     rr_ptr;

  logic [N-1:0]     grant;
  logic [C-1:0]     slot_used;
  logic [PTR_W-1:0] slot_lane [C];
  logic [PTR_W-1:0] last_lane;
  logic             any_grant;
  logic [PTR_W:0]   scan;
  logic [PTR_W-1:0] lane;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] next_ptr;

  // Round-robin scan from rr_ptr: the k-th held lane found fills slot k.
  always_comb begin
    grant     = '0;
    slot_used = '0;
    last_lane = '0;
    any_grant = 1'b0;
    cnt       = '0;
    scan      = '0;
    lane      = '0;
    for (int j = 0; j < C; j++) slot_lane[j] = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (scan >= N_EXT) scan = scan - N_EXT;
      lane = scan[PTR_W-1:0];
      if (held_valid[lane] && (cnt < C_CNT)) begin
        grant[lane]    = 1'b1;
        slot_used[cnt] = 1'b1;
        slot_lane[cnt] = lane;
        last_lane      = lane;
        any_grant      = 1'b1;
        cnt            = cnt + 1'b1;
      end
    end
  end

  // Pointer moves just past the last lane served, wrapping at N.
  assign next_ptr = (last_lane == LAST_LANE) ? '0 : last_lane + 1'b1;

  assign fu_stall = held_valid & ~grant;

  // Holding registers, CDB slots and pointer; squash wins over capture/grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_valid      <= '0;
      held_branch     <= '0;
      rr_ptr          <= '0;
      cdb_valid       <= '0;
      cdb_result      <= '0;
      cdb_dest_prf    <= '0;
      cdb_rob_idx     <= '0;
      cdb_take_branch <= '0;
      for (int i = 0; i < N; i++) begin
        held_result[i] <= '0;
        held_dest[i]   <= '0;
        held_rob[i]    <= '0;
      end
    end else if (squash) begin
      held_valid      <= '0;
      rr_ptr          <= '0;
      cdb_valid       <= '0;
      cdb_result      <= '0;
      cdb_dest_prf    <= '0;
      cdb_rob_idx     <= '0;
      cdb_take_branch <= '0;
    end else begin
      for (int j = 0; j < C; j++) begin
        if (slot_used[j]) begin
          cdb_valid[j]                             <= 1'b1;
          cdb_result[j*XLEN +: XLEN]               <= held_result[slot_lane[j]];
          cdb_dest_prf[j*PRF_IDX_W +: PRF_IDX_W]   <= held_dest[slot_lane[j]];
          cdb_rob_idx[j*ROB_IDX_W +: ROB_IDX_W]    <= held_rob[slot_lane[j]];
          cdb_take_branch[j]                       <= held_branch[slot_lane[j]];
        end else begin
          cdb_valid[j]                             <= 1'b0;
          cdb_result[j*XLEN +: XLEN]               <= '0;
          cdb_dest_prf[j*PRF_IDX_W +: PRF_IDX_W]   <= '0;
          cdb_rob_idx[j*ROB_IDX_W +: ROB_IDX_W]    <= '0;
          cdb_take_branch[j]                       <= 1'b0;
        end
      end
      // A lane accepts new input when empty or draining this cycle.
      for (int i = 0; i < N; i++) begin
        if (!held_valid[i] || grant[i]) begin
          held_valid[i] <= ex_done[i];
          if (ex_done[i]) begin
            held_result[i] <= ex_result[i*XLEN +: XLEN];
            held_dest[i]   <= ex_dest_prf[i*PRF_IDX_W +: PRF_IDX_W];
            held_rob[i]    <= ex_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            held_branch[i] <= ex_take_branch[i];
          end
        end
      end
      if (any_grant) rr_ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// Directed bench for cdb_complete_arbiter: expected broadcasts are queued as
// stimulus is issued and a negedge monitor pops and compares each one.
module tb_cdb_complete_arbiter;

  localparam int N    = 5;
  localparam int C    = 3;
  localparam int XLEN = 32;
  localparam int PW   = 6;
  localparam int RW   = 5;
  localparam int W    = C + C*XLEN + C*PW + C*RW + C;

  // Clock and reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic [N-1:0]      ex_done;
  logic [N*XLEN-1:0] ex_result;
  logic [N*PW-1:0]   ex_dest_prf;
  logic [N*RW-1:0]   ex_rob_idx;
  logic [N-1:0]      ex_take_branch;
  logic              squash;
  logic [N-1:0]      fu_stall;
  logic [C-1:0]      cdb_valid;
  logic [C*XLEN-1:0] cdb_result;
  logic [C*PW-1:0]   cdb_dest_prf;
  logic [C*RW-1:0]   cdb_rob_idx;
  logic [C-1:0]      cdb_take_branch;

  cdb_complete_arbiter #(.N(N), .C(C), .XLEN(XLEN), .PRF_IDX_W(PW), .ROB_IDX_W(RW)) dut (
    .clock(clock), .reset(reset),
    .ex_done(ex_done), .ex_result(ex_result), .ex_dest_prf(ex_dest_prf),
    .ex_rob_idx(ex_rob_idx), .ex_take_branch(ex_take_branch), .squash(squash),
    .fu_stall(fu_stall), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
    .cdb_dest_prf(cdb_dest_prf), .cdb_rob_idx(cdb_rob_idx),
    .cdb_take_branch(cdb_take_branch)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  logic [C-1:0]      e_valid, e_br;
  logic [C*XLEN-1:0] e_res;
  logic [C*PW-1:0]   e_tag;
  logic [C*RW-1:0]   e_rob;
  logic [W-1:0]      mon_got, mon_want;

  // Lane payload generator: tag/rob/branch derive from the lane number.
  function automatic logic [31:0] fres(input int g, input int lane);
    return 32'h1000 + 32'(g) * 32'h100 + 32'(lane);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  // Driver tasks
  task automatic drive_lane(input int lane, input logic [XLEN-1:0] res);
    ex_done[lane]               = 1'b1;
    ex_result[lane*XLEN +: XLEN] = res;
    ex_dest_prf[lane*PW +: PW]  = PW'(lane + 1);
    ex_rob_idx[lane*RW +: RW]   = RW'(lane + 8);
    ex_take_branch[lane]        = lane[0];
  endtask

  task automatic idle_all();
    ex_done = '0;
  endtask

  task automatic exp_clear();
    e_valid = '0; e_br = '0; e_res = '0; e_tag = '0; e_rob = '0;
  endtask

  task automatic exp_lane(input int k, input int lane, input logic [XLEN-1:0] res);
    e_valid[k]              = 1'b1;
    e_res[k*XLEN +: XLEN]   = res;
    e_tag[k*PW +: PW]       = PW'(lane + 1);
    e_rob[k*RW +: RW]       = RW'(lane + 8);
    e_br[k]                 = lane[0];
  endtask

  task automatic exp_push();
    exp_q.push_back({e_valid, e_res, e_tag, e_rob, e_br});
  endtask

  // Scoreboard monitor: every visible broadcast must match the queue head.
  always @(negedge clock) begin
    if (reset && cdb_valid != '0) begin
      mon_got = {cdb_valid, cdb_result, cdb_dest_prf, cdb_rob_idx, cdb_take_branch};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected actual %h required none", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL cdb_broadcast actual %h required %h", mon_got, mon_want);
        end
      end
    end
  end

  logic [N-1:0] stall_exp [4];

  initial begin
    reset = 1'b0; squash = 1'b0;
    ex_done = '0; ex_result = '0; ex_dest_prf = '0; ex_rob_idx = '0; ex_take_branch = '0;
    stall_exp[0] = 5'b11000; stall_exp[1] = 5'b00110;
    stall_exp[2] = 5'b10001; stall_exp[3] = 5'b01100;

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_cdb_valid", 32'(cdb_valid), 32'h0);
    chk("reset_fu_stall", 32'(fu_stall), 32'h0);
    chk("reset_cdb_data", 32'(cdb_result[31:0] | cdb_result[95:64]), 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // Three results
    exp_clear(); exp_lane(0, 0, 50); exp_lane(1, 1, 90); exp_lane(2, 2, 13); exp_push();
    drive_lane(0, 50); drive_lane(1, 90); drive_lane(2, 13);
    @(negedge clock); idle_all();
    chk("three_fu_stall", 32'(fu_stall), 32'h0);
    @(negedge clock);
    chk("three_cdb_valid", 32'(cdb_valid), 32'h7);
    chk("three_rr_ptr", 32'(dut.rr_ptr), 32'd3);
    squash = 1'b1;
    @(negedge clock); squash = 1'b0;
    chk("squash_idle_rr_ptr", 32'(dut.rr_ptr), 32'd0);

    // Oversubscription
    exp_clear(); exp_lane(0, 0, 50); exp_lane(1, 1, 90); exp_lane(2, 2, 13); exp_push();
    exp_clear(); exp_lane(0, 3, 7); exp_lane(1, 4, 32'hA000_0000); exp_push();
    drive_lane(0, 50); drive_lane(1, 90); drive_lane(2, 13); drive_lane(3, 7);
    drive_lane(4, 32'hA000_0000);
    @(negedge clock); idle_all();
    chk("over_fu_stall", 32'(fu_stall), 32'b11000);
    @(negedge clock);
    chk("over_fu_stall_2", 32'(fu_stall), 32'h0);
    chk("over_rr_ptr_1", 32'(dut.rr_ptr), 32'd3);
    @(negedge clock);
    chk("over_cdb_valid_2", 32'(cdb_valid), 32'b011);
    chk("over_rr_ptr_2", 32'(dut.rr_ptr), 32'd0);

    // Fairness: every lane done every cycle for four cycles
    exp_clear(); exp_lane(0, 0, fres(0, 0)); exp_lane(1, 1, fres(0, 1)); exp_lane(2, 2, fres(0, 2)); exp_push();
    exp_clear(); exp_lane(0, 3, fres(0, 3)); exp_lane(1, 4, fres(0, 4)); exp_lane(2, 0, fres(1, 0)); exp_push();
    exp_clear(); exp_lane(0, 1, fres(1, 1)); exp_lane(1, 2, fres(1, 2)); exp_lane(2, 3, fres(2, 3)); exp_push();
    exp_clear(); exp_lane(0, 4, fres(2, 4)); exp_lane(1, 0, fres(2, 0)); exp_lane(2, 1, fres(3, 1)); exp_push();
    exp_clear(); exp_lane(0, 2, fres(3, 2)); exp_lane(1, 3, fres(3, 3)); exp_push();
    for (int g = 0; g < 4; g++) begin
      for (int l = 0; l < N; l++) drive_lane(l, fres(g, l));
      @(negedge clock);
      chk($sformatf("fair_fu_stall_%0d", g), 32'(fu_stall), 32'(stall_exp[g]));
    end
    idle_all();
    repeat (2) @(negedge clock);
    chk("fair_rr_ptr", 32'(dut.rr_ptr), 32'd4);

    // Drain and fill on the same edge
    exp_clear(); exp_lane(0, 2, 500); exp_push();
    exp_clear(); exp_lane(0, 2, 1000); exp_push();
    drive_lane(2, 500);
    @(negedge clock);
    chk("fill_fu_stall", 32'(fu_stall), 32'h0);
    drive_lane(2, 1000);
    @(negedge clock); idle_all();
    chk("fill_first_valid", 32'(cdb_valid), 32'b001);
    @(negedge clock);
    chk("fill_no_bubble", 32'(cdb_valid), 32'b001);
    squash = 1'b1;
    @(negedge clock); squash = 1'b0;
    chk("fill_squash_rr_ptr", 32'(dut.rr_ptr), 32'd0);

    // Squash with lanes 3,4 stalled and a new lane-0 result arriving
    for (int l = 0; l < N; l++) drive_lane(l, fres(5, l));
    @(negedge clock);
    chk("squash_pre_stall", 32'(fu_stall), 32'b11000);
    idle_all(); drive_lane(0, 32'hDEAD); squash = 1'b1;
    @(negedge clock); squash = 1'b0; idle_all();
    chk("squash_cdb_valid", 32'(cdb_valid), 32'h0);
    chk("squash_fu_stall", 32'(fu_stall), 32'h0);
    chk("squash_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    repeat (3) @(negedge clock);

    // Reset mid-operation
    for (int l = 0; l < N; l++) drive_lane(l, fres(6, l));
    @(negedge clock);
    @(posedge clock); #2;
    chk("pre_reset_valid", 32'(cdb_valid), 32'h7);
    chk("pre_reset_stall", 32'(fu_stall), 32'b00110);
    reset = 1'b0;
    #1;
    chk("async_reset_valid", 32'(cdb_valid), 32'h0);
    chk("async_reset_stall", 32'(fu_stall), 32'h0);
    chk("async_reset_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    @(negedge clock); idle_all(); reset = 1'b1;
    @(negedge clock);
    exp_clear(); exp_lane(0, 0, 77); exp_push();
    drive_lane(0, 77);
    @(negedge clock); idle_all();
    chk("post_reset_not_yet", 32'(cdb_valid), 32'h0);
    @(negedge clock);
    chk("post_reset_latency", 32'(cdb_valid), 32'b001);
    repeat (2) @(negedge clock);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
